control_unit: RTL and testbench

Multi-cycle hardwired sequencer that drives every control strobe of the single-bus `datapath`. It decodes the latched instruction register and the branch-condition flag, then steps each instruction through fetch and execute cycles. It sits directly upstream of `datapath`; its outputs connect one-to-one to the datapath control inputs of the same name.

---
 rtl/control_unit.sv | 191 +++++++++++++++++++
 tb/tb_control_unit.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// Multi-cycle hardwired sequencer for the single-bus datapath: three-step fetch
// followed by up to five execute steps, with every strobe decoded from state and opcode.
module control_unit (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] IR,
  input  logic        CON,
  input  logic        stop,
  output logic        run,
  output logic        read,
  output logic        write,
  output logic        BAout,
  output logic        Rin,
  output logic        Rout,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        CONN_in,
  output logic        MARin,
  output logic        MDRin,
  output logic        HIin,
  output logic        LOin,
  output logic        Yin,
  output logic        Zin,
  output logic        PCin,
  output logic        IRin,
  output logic        incPC,
  output logic        InPortIn,
  output logic        OutPortIn,
  output logic        HIout,
  output logic        LOout,
  output logic        ZLowOut,
  output logic        ZHighOut,
  output logic        MDRout,
  output logic        Cout,
  output logic        InPortout,
  output logic        PCout,
  output logic [4:0]  opcode
);

  typedef enum logic [3:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  localparam logic [4:0] OP_LD   = 5'b00000, OP_LDI  = 5'b00001, OP_ST   = 5'b00010,
                         OP_ADD  = 5'b00011, OP_SUB  = 5'b00100, OP_SHR  = 5'b00101,
                         OP_SHRA = 5'b00110, OP_SHL  = 5'b00111, OP_ROR  = 5'b01000,
                         OP_ROL  = 5'b01001, OP_AND  = 5'b01010, OP_OR   = 5'b01011,
                         OP_ADDI = 5'b01100, OP_ANDI = 5'b01101, OP_ORI  = 5'b01110,
                         OP_MUL  = 5'b01111, OP_DIV  = 5'b10000, OP_NEG  = 5'b10001,
                         OP_NOT  = 5'b10010, OP_BR   = 5'b10011, OP_JR   = 5'b10100,
                         OP_JAL  = 5'b10101, OP_IN   = 5'b10110, OP_OUT  = 5'b10111,
                         OP_MFHI = 5'b11000, OP_MFLO = 5'b11001, OP_HALT = 5'b11011;

  state_t     state_q, state_d, last_state;
  logic [4:0] op;
  logic [4:0] alu_sel;
  logic       unused_ir;

  assign op        = IR[31:27];
  assign unused_ir = ^IR[26:0];

  // NOTE: state flops use non-blocking assignments; every combinational block uses blocking ones.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) state_q <= S_RESET;
    else     state_q <= state_d;
  end

  // Final execute step per instruction class; unlisted codes behave as nop.
  always_comb begin
    last_state = S_T3;
    case (op)
      OP_LD, OP_ST:                                         last_state = S_T7;
      OP_MUL, OP_DIV, OP_BR:                                last_state = S_T6;
      OP_LDI, OP_ADD, OP_SUB, OP_SHR, OP_SHRA, OP_SHL,
      OP_ROR, OP_ROL, OP_AND, OP_OR,
      OP_ADDI, OP_ANDI, OP_ORI:                             last_state = S_T5;
      OP_NEG, OP_NOT, OP_JAL:                               last_state = S_T4;
      default:                                              last_state = S_T3;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET: state_d = S_T0;
      S_HALT:  state_d = S_HALT;
      default: begin
        if (state_q == last_state) begin
          if (op == OP_HALT || stop) state_d = S_HALT;
          else                       state_d = S_T0;
        end else begin
          state_d = state_t'(state_q + 4'd1);
        end
      end
    endcase
  end

  // NOTE: every output gets a default before the case so the decode never infers a latch.
  always_comb begin
    {read, write, BAout, Rin, Rout, Gra, Grb, Grc, CONN_in, MARin, MDRin, HIin, LOin,
     Yin, Zin, PCin, IRin, incPC, InPortIn, OutPortIn, HIout, LOout, ZLowOut, ZHighOut,
     MDRout, Cout, InPortout, PCout} = '0;
    run = (state_q != S_RESET) && (state_q != S_HALT);

    case (state_q)
      S_T0: begin PCout = 1'b1; MARin = 1'b1; incPC = 1'b1; end
      S_T1: begin read = 1'b1; MDRin = 1'b1; end
      S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
      S_T3, S_T4, S_T5, S_T6, S_T7: begin
        case (op)
          OP_ADD, OP_SUB, OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL, OP_AND, OP_OR:
            case (state_q)
              S_T3:    begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
              S_T4:    begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; end
              S_T5:    begin ZLowOut = 1'b1; Gra = 1'b1; Rin = 1'b1; end
              default: ;
            endcase
          // Immediate forms share base+constant address arithmetic; ld/ldi/st zero-base via BAout.
          OP_ADDI, OP_ANDI, OP_ORI, OP_LDI, OP_LD, OP_ST:
            case (state_q)
              S_T3: begin
                Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
                BAout = (op == OP_LDI) || (op == OP_LD) || (op == OP_ST);
              end
              S_T4: begin Cout = 1'b1; Zin = 1'b1; end
              S_T5: begin
                ZLowOut = 1'b1;
                if (op == OP_LD || op == OP_ST) MARin = 1'b1;
                else begin Gra = 1'b1; Rin = 1'b1; end
              end
              S_T6: begin
                MDRin = 1'b1;
                if (op == OP_LD) read = 1'b1;
                else begin Gra = 1'b1; Rout = 1'b1; end
              end
              S_T7: begin
                if (op == OP_LD) begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                else write = 1'b1;
              end
              default: ;
            endcase
          OP_NEG, OP_NOT:
            case (state_q)
              S_T3:    begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; end
              S_T4:    begin ZLowOut = 1'b1; Gra = 1'b1; Rin = 1'b1; end
              default: ;
            endcase
          OP_MUL, OP_DIV:
            case (state_q)
              S_T3:    begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
              S_T4:    begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; end
              S_T5:    begin ZLowOut = 1'b1; LOin = 1'b1; end
              S_T6:    begin ZHighOut = 1'b1; HIin = 1'b1; end
              default: ;
            endcase
          OP_BR:
            case (state_q)
              S_T3:    begin Gra = 1'b1; Rout = 1'b1; CONN_in = 1'b1; end
              S_T4:    begin PCout = 1'b1; Yin = 1'b1; end
              S_T5:    begin Cout = 1'b1; Zin = 1'b1; end
              S_T6:    begin ZLowOut = CON; PCin = CON; end
              default: ;
            endcase
          OP_JR:   if (state_q == S_T3) begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
          OP_JAL:
            case (state_q)
              S_T3:    begin PCout = 1'b1; Grb = 1'b1; Rin = 1'b1; end
              S_T4:    begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
              default: ;
            endcase
          OP_IN:   if (state_q == S_T3) begin InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          OP_OUT:  if (state_q == S_T3) begin Gra = 1'b1; Rout = 1'b1; OutPortIn = 1'b1; end
          OP_MFHI: if (state_q == S_T3) begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          OP_MFLO: if (state_q == S_T3) begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          default: ;
        endcase
      end
      default: ;
    endcase

    case (op)
      OP_LD, OP_LDI, OP_ST, OP_BR, OP_ADDI: alu_sel = OP_ADD;
      OP_ANDI:                              alu_sel = OP_AND;
      OP_ORI:                               alu_sel = OP_OR;
      default:                              alu_sel = op;
    endcase
    opcode = Zin ? alu_sel : 5'b00000;
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: walks each instruction class step by step and
// compares run/opcode/strobes against hand-written expected tables.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic [31:0] IR = '0;
  logic        CON = 1'b0;
  logic        stop = 1'b0;
  logic        run, read, write, BAout, Rin, Rout, Gra, Grb, Grc, CONN_in, MARin, MDRin;
  logic        HIin, LOin, Yin, Zin, PCin, IRin, incPC, InPortIn, OutPortIn, HIout, LOout;
  logic        ZLowOut, ZHighOut, MDRout, Cout, InPortout, PCout;
  logic [4:0]  opcode;
  logic [27:0] strb;
  int          checks = 0;
  int          errors = 0;

  localparam logic [27:0] M_READ  = 28'd1 << 0,  M_WRITE = 28'd1 << 1,  M_BAOUT = 28'd1 << 2,
                          M_RIN   = 28'd1 << 3,  M_ROUT  = 28'd1 << 4,  M_GRA   = 28'd1 << 5,
                          M_GRB   = 28'd1 << 6,  M_GRC   = 28'd1 << 7,  M_CONN  = 28'd1 << 8,
                          M_MARIN = 28'd1 << 9,  M_MDRIN = 28'd1 << 10, M_YIN   = 28'd1 << 13,
                          M_ZIN   = 28'd1 << 14, M_PCIN  = 28'd1 << 15, M_IRIN  = 28'd1 << 16,
                          M_INCPC = 28'd1 << 17, M_ZLOW  = 28'd1 << 22, M_MDROUT = 28'd1 << 24,
                          M_COUT  = 28'd1 << 25, M_PCOUT = 28'd1 << 27;
  localparam logic [27:0] F0 = M_PCOUT | M_MARIN | M_INCPC;
  localparam logic [27:0] F1 = M_READ | M_MDRIN;
  localparam logic [27:0] F2 = M_MDROUT | M_IRIN;

  control_unit dut (
    .clk(clk), .clr(clr), .IR(IR), .CON(CON), .stop(stop), .run(run),
    .read(read), .write(write), .BAout(BAout), .Rin(Rin), .Rout(Rout), .Gra(Gra),
    .Grb(Grb), .Grc(Grc), .CONN_in(CONN_in), .MARin(MARin), .MDRin(MDRin), .HIin(HIin),
    .LOin(LOin), .Yin(Yin), .Zin(Zin), .PCin(PCin), .IRin(IRin), .incPC(incPC),
    .InPortIn(InPortIn), .OutPortIn(OutPortIn), .HIout(HIout), .LOout(LOout),
    .ZLowOut(ZLowOut), .ZHighOut(ZHighOut), .MDRout(MDRout), .Cout(Cout),
    .InPortout(InPortout), .PCout(PCout), .opcode(opcode)
  );

  assign strb = {PCout, InPortout, Cout, MDRout, ZHighOut, ZLowOut, LOout, HIout, OutPortIn,
                 InPortIn, incPC, IRin, PCin, Zin, Yin, LOin, HIin, MDRin, MARin, CONN_in,
                 Grc, Grb, Gra, Rout, Rin, BAout, write, read};

  always #5 clk = ~clk;

  // Leaves the DUT in RESET; the next rising edge enters T0.
  task automatic do_reset();
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
  endtask

  task automatic test_reset();
    IR = 32'h1800_0000; stop = 1'b0;
    do_reset();
    checks++;
    if ({run, opcode, strb} !== 34'd0) begin
      errors++; $display("FAIL reset_idle: got run=%b op=%b strb=%h, expected all zero", run, opcode, strb);
    end
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if ({run, opcode, strb} !== {1'b1, 5'b00011, M_GRC | M_ROUT | M_ZIN}) begin
      errors++; $display("FAIL reset_pre_T4: got run=%b op=%b strb=%h, expected run=1 op=00011 strb=%h", run, opcode, strb, M_GRC | M_ROUT | M_ZIN);
    end
    #1 clr = 1'b1;
    #1;
    checks++;
    if ({run, opcode, strb} !== 34'd0) begin
      errors++; $display("FAIL reset_async: got run=%b op=%b strb=%h, expected all zero", run, opcode, strb);
    end
    @(negedge clk); clr = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({run, opcode, strb} !== {1'b1, 5'b00000, F0}) begin
      errors++; $display("FAIL reset_T0: got run=%b op=%b strb=%h, expected run=1 op=00000 strb=%h", run, opcode, strb, F0);
    end
  endtask

  task automatic test_add();
    logic [27:0] es [7];
    logic [4:0]  eo [7];
    es = '{F0, F1, F2, M_GRB | M_ROUT | M_YIN, M_GRC | M_ROUT | M_ZIN, M_ZLOW | M_GRA | M_RIN, F0};
    eo = '{default: 5'd0};
    eo[4] = 5'b00011;
    IR = 32'h1800_0000;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({run, opcode, strb} !== {1'b1, eo[i], es[i]}) begin
        errors++; $display("FAIL add step %0d: got run=%b op=%b strb=%h, expected run=1 op=%b strb=%h", i, run, opcode, strb, eo[i], es[i]);
      end
    end
  endtask

  task automatic test_ld_st();
    logic [27:0] es [9];
    logic [4:0]  eo [9];
    eo = '{default: 5'd0};
    eo[4] = 5'b00011;
    for (int k = 0; k < 2; k++) begin
      es = '{F0, F1, F2, M_GRB | M_ROUT | M_BAOUT | M_YIN, M_COUT | M_ZIN, M_ZLOW | M_MARIN,
             M_READ | M_MDRIN, M_MDROUT | M_GRA | M_RIN, F0};
      if (k == 1) begin
        es[6] = M_GRA | M_ROUT | M_MDRIN;
        es[7] = M_WRITE;
      end
      IR = (k == 0) ? 32'h0000_0000 : 32'h1000_0000;
      do_reset();
      for (int i = 0; i < 9; i++) begin
        @(posedge clk); #1;
        checks++;
        if ({run, opcode, strb} !== {1'b1, eo[i], es[i]}) begin
          errors++; $display("FAIL %s step %0d: got run=%b op=%b strb=%h, expected run=1 op=%b strb=%h", (k == 0) ? "ld" : "st", i, run, opcode, strb, eo[i], es[i]);
        end
      end
    end
  endtask

  task automatic test_br();
    logic [27:0] es [8];
    logic [4:0]  eo [8];
    eo = '{default: 5'd0};
    eo[5] = 5'b00011;
    for (int k = 0; k < 2; k++) begin
      es = '{F0, F1, F2, M_GRA | M_ROUT | M_CONN, M_PCOUT | M_YIN, M_COUT | M_ZIN, M_ZLOW | M_PCIN, F0};
      if (k == 1) es[6] = '0;
      IR = 32'h9800_0000;
      CON = (k == 0);
      do_reset();
      for (int i = 0; i < 8; i++) begin
        @(posedge clk); #1;
        checks++;
        if ({run, opcode, strb} !== {1'b1, eo[i], es[i]}) begin
          errors++; $display("FAIL br_con%0d step %0d: got run=%b op=%b strb=%h, expected run=1 op=%b strb=%h", 1 - k, i, run, opcode, strb, eo[i], es[i]);
        end
      end
    end
    CON = 1'b0;
  endtask

  task automatic test_imm_opcode();
    logic [27:0] es [6];
    logic [4:0]  eo [6];
    // andi: T4 selects AND; neg: T3 passes its own opcode through.
    for (int k = 0; k < 2; k++) begin
      eo = '{default: 5'd0};
      if (k == 0) begin
        IR = 32'h6800_0000;
        es = '{F0, F1, F2, M_GRB | M_ROUT | M_YIN, M_COUT | M_ZIN, M_ZLOW | M_GRA | M_RIN};
        eo[4] = 5'b01010;
      end else begin
        IR = 32'h8800_0000;
        es = '{F0, F1, F2, M_GRB | M_ROUT | M_ZIN, M_ZLOW | M_GRA | M_RIN, F0};
        eo[3] = 5'b10001;
      end
      do_reset();
      for (int i = 0; i < 6; i++) begin
        @(posedge clk); #1;
        checks++;
        if ({run, opcode, strb} !== {1'b1, eo[i], es[i]}) begin
          errors++; $display("FAIL %s step %0d: got run=%b op=%b strb=%h, expected run=1 op=%b strb=%h", (k == 0) ? "andi" : "neg", i, run, opcode, strb, eo[i], es[i]);
        end
      end
    end
  endtask

  task automatic test_halt();
    logic [27:0] es [4];
    es = '{F0, F1, F2, 28'd0};
    IR = 32'hD800_0000; stop = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({run, opcode, strb} !== {1'b1, 5'd0, es[i]}) begin
        errors++; $display("FAIL halt step %0d: got run=%b op=%b strb=%h, expected run=1 op=00000 strb=%h", i, run, opcode, strb, es[i]);
      end
    end
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({run, opcode, strb} !== 34'd0) begin
        errors++; $display("FAIL halt_hold cycle %0d: got run=%b op=%b strb=%h, expected all zero", i, run, opcode, strb);
      end
    end
  endtask

  task automatic test_stop();
    logic [27:0] es [8];
    logic [4:0]  eo [8];
    logic        er [8];
    logic        sp [8];
    es = '{F0, F1, F2, M_GRB | M_ROUT | M_YIN, M_COUT | M_ZIN, M_ZLOW | M_GRA | M_RIN, 28'd0, 28'd0};
    eo = '{default: 5'd0};
    eo[4] = 5'b00011;
    er = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    // stop raised in T3 must be ignored; raised in T5 (last step) it halts.
    sp = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    IR = 32'h6000_0000; stop = 1'b0;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({run, opcode, strb} !== {er[i], eo[i], es[i]}) begin
        errors++; $display("FAIL stop_addi step %0d: got run=%b op=%b strb=%h, expected run=%b op=%b strb=%h", i, run, opcode, strb, er[i], eo[i], es[i]);
      end
      stop = sp[i];
    end
  endtask

  task automatic test_unknown();
    logic [27:0] es [9];
    es = '{F0, F1, F2, 28'd0, F0, F1, F2, 28'd0, F0};
    IR = 32'hF800_0000; stop = 1'b0;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({run, opcode, strb} !== {1'b1, 5'd0, es[i]}) begin
        errors++; $display("FAIL unknown_op step %0d: got run=%b op=%b strb=%h, expected run=1 op=00000 strb=%h", i, run, opcode, strb, es[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_ld_st();
    test_br();
    test_imm_opcode();
    test_halt();
    test_stop();
    test_unknown();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
